dec_i2c_slave_regs: RTL and testbench

I2C target (responder) model of the video decoder's register port: accepts the sub-address/data write transactions produced by the decoder configuration sequencer, stores them in an internal 256×8 register file, and returns register contents on I2C reads. Sits on the I2C bus opposite the configuration master. It is used as the bus target in system simulation and as an on-FPGA readback/loopback target for bring-up. Every accepted write is also mirrored on a parallel strobe port for monitoring.

---
 rtl/dec_i2c_slave_regs_if.sv | 25 ++
 rtl/dec_i2c_slave_regs.sv | 218 +++++++++++++++++++++
 tb/tb_dec_i2c_slave_regs.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_i2c_slave_regs_if.sv
`default_nettype none
// ============================================================================
// dec_i2c_slave_regs_if : I2C pad signals and write-mirror port of the decoder
//                         register target.   Rev 1.0
// ============================================================================
interface dec_i2c_slave_regs_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic       write;
   logic [7:0] SubAddrL;
   logic [7:0] data;
   logic       busy;

   modport master (
      output scl_in, sda_in,
      input  sda_oe, write, SubAddrL, data, busy
   );

   modport slave (
      input  scl_in, sda_in,
      output sda_oe, write, SubAddrL, data, busy
   );
endinterface
`default_nettype wire

// File: rtl/dec_i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// dec_i2c_slave_regs : I2C target with 256x8 register file and write mirror.
// Rev 1.0 -- define DEC_I2C_SLAVE_AUTOINC_EN for sub-address auto-increment.
// ============================================================================
module dec_i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h20
) (
   input wire                  clk,
   input wire                  reset,
   dec_i2c_slave_regs_if.slave bus_if
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_DEVADDR   = 4'd1,
      S_ACK_DEV   = 4'd2,
      S_SUBADDR   = 4'd3,
      S_ACK_SUB   = 4'd4,
      S_WDATA     = 4'd5,
      S_ACK_WDATA = 4'd6,
      S_RDATA     = 4'd7,
      S_MACK      = 4'd8,
      S_IGNORE    = 4'd9
   } state_t;

   state_t     state_q;
   logic       scl_s1_q, scl_s2_q, scl_h_q;
   logic       sda_s1_q, sda_s2_q, sda_h_q;
   logic       scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;
   logic [7:0] shreg_q, ptr_q, subaddr_q, data_q;
   logic [3:0] bitcnt_q;
   logic       rw_q, mack_q, sda_oe_q, write_q, busy_q;
   logic [7:0] regs_q [256];

   logic [7:0] ptr_d;
   logic [7:0] w_shift, w_rd_cur, w_rd_nxt;
   logic       w_wr_en;

`ifdef DEC_I2C_SLAVE_AUTOINC_EN
   assign ptr_d = ptr_q + 8'd1;
`else
   assign ptr_d = ptr_q;
`endif

   assign w_shift  = {shreg_q[6:0], sda_bit_q};
   assign w_rd_cur = regs_q[ptr_q];
   assign w_rd_nxt = regs_q[ptr_d];
   assign w_wr_en  = (state_q == S_WDATA) && scl_rise_q && (bitcnt_q == 4'd7)
                     && !stop_q && !start_q;

   // Synchronizer, history and a registered compare stage: events reach the FSM 3 clk after the pad.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_h_q    <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_h_q    <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         sda_bit_q  <= 1'b1;
      end else begin
         scl_s1_q   <= bus_if.scl_in;
         scl_s2_q   <= scl_s1_q;
         scl_h_q    <= scl_s2_q;
         sda_s1_q   <= bus_if.sda_in;
         sda_s2_q   <= sda_s1_q;
         sda_h_q    <= sda_s2_q;
         scl_rise_q <= scl_s2_q & ~scl_h_q;
         scl_fall_q <= ~scl_s2_q & scl_h_q;
         start_q    <= scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
         stop_q     <= scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
         sda_bit_q  <= sda_s2_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         shreg_q   <= 8'h00;
         ptr_q     <= 8'h00;
         subaddr_q <= 8'h00;
         data_q    <= 8'h00;
         bitcnt_q  <= 4'd0;
         rw_q      <= 1'b0;
         mack_q    <= 1'b1;
         sda_oe_q  <= 1'b0;
         write_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         write_q <= 1'b0;
         // STOP outranks START, which outranks any SCL edge in the same cycle.
         if (stop_q) begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            bitcnt_q <= 4'd0;
         end else if (start_q) begin
            state_q  <= S_DEVADDR;
            bitcnt_q <= 4'd0;
         end else begin
            case (state_q)
               S_DEVADDR: begin
                  if (scl_rise_q && bitcnt_q != 4'd8) begin
                     shreg_q  <= w_shift;
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall_q && bitcnt_q == 4'd8) begin
                     bitcnt_q <= 4'd0;
                     if (shreg_q[7:1] == DEV_ADDR) begin
                        sda_oe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        rw_q     <= shreg_q[0];
                        state_q  <= S_ACK_DEV;
                     end else begin
                        state_q  <= S_IGNORE;
                     end
                  end
               end
               S_ACK_DEV: begin
                  if (scl_fall_q) begin
                     if (rw_q) begin
                        shreg_q  <= w_rd_cur;
                        sda_oe_q <= ~w_rd_cur[7];
                        state_q  <= S_RDATA;
                     end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_SUBADDR;
                     end
                  end
               end
               S_SUBADDR: begin
                  if (scl_rise_q && bitcnt_q != 4'd8) begin
                     shreg_q  <= w_shift;
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall_q && bitcnt_q == 4'd8) begin
                     bitcnt_q <= 4'd0;
                     ptr_q    <= shreg_q;
                     sda_oe_q <= 1'b1;
                     state_q  <= S_ACK_SUB;
                  end
               end
               S_ACK_SUB, S_ACK_WDATA: begin
                  if (scl_fall_q) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= S_WDATA;
                  end
               end
               S_WDATA: begin
                  if (scl_rise_q && bitcnt_q != 4'd8) begin
                     shreg_q  <= w_shift;
                     bitcnt_q <= bitcnt_q + 4'd1;
                     if (w_wr_en) begin
                        write_q   <= 1'b1;
                        subaddr_q <= ptr_q;
                        data_q    <= w_shift;
                        ptr_q     <= ptr_d;
                     end
                  end else if (scl_fall_q && bitcnt_q == 4'd8) begin
                     bitcnt_q <= 4'd0;
                     sda_oe_q <= 1'b1;
                     state_q  <= S_ACK_WDATA;
                  end
               end
               S_RDATA: begin
                  if (scl_rise_q && bitcnt_q != 4'd8) begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall_q) begin
                     if (bitcnt_q == 4'd8) begin
                        bitcnt_q <= 4'd0;
                        sda_oe_q <= 1'b0;
                        state_q  <= S_MACK;
                     end else begin
                        shreg_q  <= {shreg_q[6:0], 1'b0};
                        sda_oe_q <= ~shreg_q[6];
                     end
                  end
               end
               S_MACK: begin
                  if (scl_rise_q) begin
                     mack_q <= sda_bit_q;
                  end else if (scl_fall_q) begin
                     if (!mack_q) begin
                        ptr_q    <= ptr_d;
                        shreg_q  <= w_rd_nxt;
                        sda_oe_q <= ~w_rd_nxt[7];
                        state_q  <= S_RDATA;
                     end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_IGNORE;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Register file deliberately has no reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         regs_q[ptr_q] <= w_shift;
      end
   end

   assign bus_if.sda_oe   = sda_oe_q;
   assign bus_if.write    = write_q;
   assign bus_if.SubAddrL = subaddr_q;
   assign bus_if.data     = data_q;
   assign bus_if.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// tb_dec_i2c_slave_regs : directed I2C master bench for dec_i2c_slave_regs.
// Rev 1.0
// ============================================================================
module tb_dec_i2c_slave_regs;

   localparam int Q = 10;  // clk cycles per quarter SCL period

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mon_sub [$];
   logic [7:0] mon_dat [$];

   dec_i2c_slave_regs_if bus_if ();

   assign bus_if.scl_in = scl_m;
   assign bus_if.sda_in = sda_m & ~bus_if.sda_oe;

   dec_i2c_slave_regs #(.DEV_ADDR(7'h20)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_if (bus_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset && bus_if.write === 1'b1) begin
         mon_sub.push_back(bus_if.SubAddrL);
         mon_dat.push_back(bus_if.data);
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wq();
         scl_m = 1'b1; wq(); wq();
         scl_m = 1'b0; wq();
      end
   endtask

   task automatic ack_clock(output logic a);
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      a = bus_if.sda_in; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic a);
      send_bits(b);
      ack_clock(a);
   endtask

   task automatic recv_byte(output logic [7:0] b, input logic mack);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         wq();
         scl_m = 1'b1; wq();
         b[i] = bus_if.sda_in; wq();
         scl_m = 1'b0;
      end
      wq();
      sda_m = mack; wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
      sda_m = 1'b1;
   endtask

   task automatic wr_txn(input logic [7:0] sub, input logic [7:0] d, output logic [2:0] acks);
      i2c_start();
      send_byte(8'h40, acks[2]);
      send_byte(sub,   acks[1]);
      send_byte(d,     acks[0]);
      i2c_stop();
      wq();
   endtask

   task automatic rd_txn(input logic [7:0] sub, output logic [7:0] d, output logic [2:0] acks);
      i2c_start();
      send_byte(8'h40, acks[2]);
      send_byte(sub,   acks[1]);
      i2c_start();
      send_byte(8'h41, acks[0]);
      recv_byte(d, 1'b1);
      i2c_stop();
      wq();
   endtask

   logic [7:0] cfg_sub [20] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'hFA};
   logic [7:0] cfg_dat [20] = '{8'h01, 8'h80, 8'h47, 8'h00, 8'h07, 8'h10, 8'h20, 8'h0C, 8'h80, 8'h00,
                                8'h00, 8'h00, 8'h41, 8'h00, 8'h04, 8'h80, 8'h1E, 8'h06, 8'h09, 8'h03};

   initial begin
      logic       a;
      logic [2:0] acks;
      logic [3:0] acks4;
      logic [7:0] rd, rd2;
      int         n0;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      chk("rst_sda_oe",   bus_if.sda_oe,   1'b0);
      chk("rst_write",    bus_if.write,    1'b0);
      chk("rst_subaddr",  bus_if.SubAddrL, 8'h00);
      chk("rst_data",     bus_if.data,     8'h00);
      chk("rst_busy",     bus_if.busy,     1'b0);
      reset = 1'b1;
      wq();

      // Basic write 0x40,0x0A,0x01
      i2c_start();
      send_byte(8'h40, acks[2]);
      send_byte(8'h0A, acks[1]);
      send_byte(8'h01, acks[0]);
      chk("t1_busy_in",  bus_if.busy, 1'b1);
      i2c_stop();
      wq();
      chk("t1_acks",     acks, 3'b000);
      chk("t1_busy_out", bus_if.busy, 1'b0);
      chk("t1_nwrite",   mon_sub.size(), 1);
      chk("t1_sub",      mon_sub[0], 8'h0A);
      chk("t1_data",     mon_dat[0], 8'h01);

      // Address mismatch, then a valid transaction
      n0 = mon_sub.size();
      i2c_start();
      send_byte(8'h42, a);
      chk("t2_nack_addr", a, 1'b1);
      send_byte(8'h0A, a);
      chk("t2_nack_sub",  a, 1'b1);
      chk("t2_busy",      bus_if.busy, 1'b0);
      chk("t2_sda_oe",    bus_if.sda_oe, 1'b0);
      i2c_stop();
      wq();
      chk("t2_nwrite",    mon_sub.size(), n0);
      wr_txn(8'h23, 8'hE6, acks);
      chk("t2_valid_acks", acks, 3'b000);
      chk("t2_valid_n",    mon_sub.size(), n0 + 1);
      chk("t2_valid_sub",  mon_sub[n0], 8'h23);
      chk("t2_valid_dat",  mon_dat[n0], 8'hE6);

      // Sub-address write then repeated-start read
      rd_txn(8'h23, rd, acks);
      chk("t3_acks", acks, 3'b000);
      chk("t3_rd",   rd,   8'hE6);

      // Two data bytes at 0xFF, then two-byte readback from 0xFF
      n0 = mon_sub.size();
      i2c_start();
      send_byte(8'h40, acks4[3]);
      send_byte(8'hFF, acks4[2]);
      send_byte(8'hAA, acks4[1]);
      send_byte(8'h55, acks4[0]);
      i2c_stop();
      wq();
      chk("t4_acks",  acks4, 4'b0000);
      chk("t4_n",     mon_sub.size(), n0 + 2);
      chk("t4_sub0",  mon_sub[n0],     8'hFF);
      chk("t4_dat0",  mon_dat[n0],     8'hAA);
      chk("t4_dat1",  mon_dat[n0 + 1], 8'h55);
`ifdef DEC_I2C_SLAVE_AUTOINC_EN
      chk("t4_sub1",  mon_sub[n0 + 1], 8'h00);
`else
      chk("t4_sub1",  mon_sub[n0 + 1], 8'hFF);
`endif
      i2c_start();
      send_byte(8'h40, acks[2]);
      send_byte(8'hFF, acks[1]);
      i2c_start();
      send_byte(8'h41, acks[0]);
      recv_byte(rd,  1'b0);
      recv_byte(rd2, 1'b1);
      i2c_stop();
      wq();
      chk("t4_rd_acks", acks, 3'b000);
`ifdef DEC_I2C_SLAVE_AUTOINC_EN
      chk("t4_rd0", rd,  8'hAA);
      chk("t4_rd1", rd2, 8'h55);
`else
      chk("t4_rd0", rd,  8'h55);
      chk("t4_rd1", rd2, 8'h55);
`endif

      // Reset while the address ACK is being driven
      wr_txn(8'h00, 8'h5A, acks);
      wr_txn(8'h37, 8'h11, acks);
      i2c_start();
      send_bits(8'h40);
      chk("t5_acking", bus_if.sda_oe, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t5_async_rel", bus_if.sda_oe, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      wq();
      chk("t5_write",   bus_if.write,    1'b0);
      chk("t5_subaddr", bus_if.SubAddrL, 8'h00);
      chk("t5_data",    bus_if.data,     8'h00);
      chk("t5_busy",    bus_if.busy,     1'b0);
      i2c_stop();
      wq();
      i2c_start();
      send_byte(8'h41, a);
      recv_byte(rd, 1'b1);
      i2c_stop();
      wq();
      chk("t5_rd_ack",  a,  1'b0);
      chk("t5_rd_ptr0", rd, 8'h5A);

      // Decoder configuration sequence and readback
      n0 = mon_sub.size();
      for (int i = 0; i < 20; i++) begin
         wr_txn(cfg_sub[i], cfg_dat[i], acks);
         chk($sformatf("cfg_ack%0d", i), acks, 3'b000);
      end
      chk("cfg_n", mon_sub.size(), n0 + 20);
      for (int i = 0; i < 20; i++) begin
         if (n0 + i < mon_sub.size()) begin
            chk($sformatf("cfg_sub%0d", i), mon_sub[n0 + i], cfg_sub[i]);
            chk($sformatf("cfg_dat%0d", i), mon_dat[n0 + i], cfg_dat[i]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         rd_txn(cfg_sub[i], rd, acks);
         chk($sformatf("cfg_rd%0d", i), rd, cfg_dat[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
